// File: rtl/readout_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : readout_sequencer
//  Description : Frame scheduler between the per-batch channel count
//                registers and a byte-wide UART transmitter. Each accepted
//                batch_done snapshots every channel count, then sends one
//                frame over the transmitter handshake:
//                    SYNC_BYTE, count[0] .. count[N_CH-1], XOR checksum
//                It also counts batches that arrive while a frame is in
//                flight, and flags a transmitter that stops answering.
//
//  Parameters  : N_CH        - number of 8-bit count channels (<= 15)
//                SYNC_BYTE   - frame header byte
//                TIMEOUT_CYC - max cycles to wait for tx_done per byte
//
//  Ports       : clk          in   system clock, rising edge
//                rst          in   asynchronous active-high reset
//                batch_done   in   one-cycle end-of-batch pulse
//                counts_flat  in   channel k at bits [8k+7:8k]
//                tx_done      in   transmitter finished current byte
//                tx_start     out  one-cycle request to send tx_data
//                tx_data      out  byte being sent (stable until tx_done)
//                selection    out  channel being sent, 4'hF for hdr/csum
//                busy         out  frame in progress
//                drop_cnt     out  batches ignored while busy (saturating)
//                timeout_err  out  sticky transmitter-timeout flag
//                frame_cnt    out  completed frames (wrapping)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module readout_sequencer #(
    parameter int         N_CH        = 9,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              batch_done,
    input  logic [8*N_CH-1:0] counts_flat,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [3:0]        selection,
    output logic              busy,
    output logic [7:0]        drop_cnt,
    output logic              timeout_err,
    output logic [15:0]       frame_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int WD_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    // The watchdog holds the number of wait cycles already spent; when the
    // current wait cycle would make it TIMEOUT_CYC, the byte has timed out.
    localparam logic [WD_W-1:0] c_wd_last  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]      c_last_ch  = 4'(N_CH - 1);
    localparam logic [3:0]      c_sel_none = 4'hF;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_hdr    = 3'd1;
    localparam logic [2:0] c_st_hdr_w  = 3'd2;
    localparam logic [2:0] c_st_dat    = 3'd3;
    localparam logic [2:0] c_st_dat_w  = 3'd4;
    localparam logic [2:0] c_st_csum   = 3'd5;
    localparam logic [2:0] c_st_csum_w = 3'd6;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]      r_state;
    logic [7:0]      r_snap [N_CH];
    logic [7:0]      r_acc;
    logic [3:0]      r_ch_idx;
    logic [WD_W-1:0] r_wd;

    // ------------------------------------------------------------------------
    // Unpack the flat count bus into per-channel bytes
    // ------------------------------------------------------------------------
    logic [7:0] w_counts [N_CH];

    genvar gk;
    generate
        for (gk = 0; gk < N_CH; gk++) begin : g_unpack
            assign w_counts[gk] = counts_flat[8*gk +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next data byte to load.
    // Outputs are registered, so the byte for the next DAT cycle is chosen
    // one cycle early: channel 0 when leaving the header wait, otherwise the
    // channel after the one just acknowledged. The mux never indexes past
    // the last channel, even when ch_idx is on the last channel.
    // ------------------------------------------------------------------------
    logic [3:0] w_load_idx;
    logic [7:0] w_load_byte;

    always_comb begin
        w_load_idx = (r_state == c_st_hdr_w) ? 4'd0 : (r_ch_idx + 4'd1);
    end

    always_comb begin
        w_load_byte = 8'h00;
        for (int k = 0; k < N_CH; k++) begin
            if (w_load_idx == 4'(k)) begin
                w_load_byte = r_snap[k];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Watchdog: cleared while tx_start is high, counts in every wait state.
    // tx_done in the same cycle as expiry wins, so a late-but-valid answer
    // still completes the byte.
    // ------------------------------------------------------------------------
    logic w_in_wait;
    logic w_wd_expired;

    always_comb begin
        w_in_wait = (r_state == c_st_hdr_w) ||
                    (r_state == c_st_dat_w) ||
                    (r_state == c_st_csum_w);
        w_wd_expired = w_in_wait && !tx_done && (r_wd == c_wd_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd <= '0;
        end else if (tx_start) begin
            r_wd <= '0;
        end else if (w_in_wait && !w_wd_expired) begin
            r_wd <= r_wd + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Dropped batch counter: any batch_done outside IDLE, including one that
    // coincides with the final tx_done of a frame.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= 8'h00;
        end else if (batch_done && (r_state != c_st_idle) &&
                     (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'h01;
        end
    end

    // ------------------------------------------------------------------------
    // Frame sequencer.
    // tx_start/tx_data/selection are loaded on the transition INTO the
    // HDR/DAT/CSUM states, so tx_start is high exactly during those states
    // and data changes only in the cycle tx_start rises.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_acc       <= 8'h00;
            r_ch_idx    <= 4'd0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            selection   <= c_sel_none;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            frame_cnt   <= 16'h0000;
            for (int k = 0; k < N_CH; k++) begin
                r_snap[k] <= 8'h00;
            end
        end else begin
            tx_start <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (batch_done) begin
                        for (int k = 0; k < N_CH; k++) begin
                            r_snap[k] <= w_counts[k];
                        end
                        r_acc     <= 8'h00;
                        busy      <= 1'b1;
                        tx_start  <= 1'b1;
                        tx_data   <= SYNC_BYTE;
                        selection <= c_sel_none;
                        r_state   <= c_st_hdr;
                    end
                end

                c_st_hdr: begin
                    r_state <= c_st_hdr_w;
                end

                c_st_dat: begin
                    r_state <= c_st_dat_w;
                end

                c_st_csum: begin
                    r_state <= c_st_csum_w;
                end

                c_st_hdr_w, c_st_dat_w: begin
                    if (tx_done) begin
                        if ((r_state == c_st_dat_w) && (r_ch_idx == c_last_ch)) begin
                            // r_acc already includes the last channel byte.
                            tx_start  <= 1'b1;
                            tx_data   <= r_acc;
                            selection <= c_sel_none;
                            r_state   <= c_st_csum;
                        end else begin
                            tx_start  <= 1'b1;
                            tx_data   <= w_load_byte;
                            selection <= w_load_idx;
                            r_ch_idx  <= w_load_idx;
                            r_acc     <= r_acc ^ w_load_byte;
                            r_state   <= c_st_dat;
                        end
                    end else if (w_wd_expired) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= c_st_idle;
                    end
                end

                c_st_csum_w: begin
                    if (tx_done) begin
                        frame_cnt <= frame_cnt + 16'h0001;
                        busy      <= 1'b0;
                        r_state   <= c_st_idle;
                    end else if (w_wd_expired) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= c_st_idle;
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_readout_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_readout_sequencer
//  Description : Directed self-checking bench for readout_sequencer, with a
//                behavioural transmitter that answers each tx_start with
//                tx_done a fixed number of cycles later and logs every byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_readout_sequencer;

    localparam int N_CH = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              batch_done = 1'b0;
    logic [8*N_CH-1:0] counts_flat = '0;
    logic              tx_done = 1'b0;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [3:0]        selection;
    logic              busy;
    logic [7:0]        drop_cnt;
    logic              timeout_err;
    logic [15:0]       frame_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_frames = 0;

    readout_sequencer #(
        .N_CH        (N_CH),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .batch_done  (batch_done),
        .counts_flat (counts_flat),
        .tx_done     (tx_done),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .selection   (selection),
        .busy        (busy),
        .drop_cnt    (drop_cnt),
        .timeout_err (timeout_err),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Transmitter model (acts on the falling edge)
    // ------------------------------------------------------------------------
    logic [7:0] log_data [0:1023];
    logic [3:0] log_sel  [0:1023];
    int         n_log    = 0;
    int         pend     = -1;
    int         tx_lat   = 20;
    int         mute_idx = -1;
    int         viol     = 0;
    logic       prev_start = 1'b0;
    logic [7:0] held = 8'h00;

    always @(negedge clk) begin
        tx_done = 1'b0;
        if (rst) begin
            pend       = -1;
            prev_start = 1'b0;
        end else begin
            if (pend > 0) begin
                if (tx_data !== held) viol++;
                pend--;
                if (pend == 0) begin
                    tx_done = 1'b1;
                    pend    = -1;
                end
            end
            if (tx_start === 1'b1) begin
                if (prev_start) viol++;
                if (n_log < 1024) begin
                    log_data[n_log] = tx_data;
                    log_sel[n_log]  = selection;
                end
                n_log++;
                held = tx_data;
                if (n_log != mute_idx) pend = tx_lat;
            end
            prev_start = tx_start;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // ------------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_batch();
        batch_done = 1'b1;
        tick();
        batch_done = 1'b0;
    endtask

    task automatic set_counts(input logic [7:0] first);
        for (int k = 0; k < N_CH; k++) counts_flat[8*k +: 8] = first + 8'(k);
    endtask

    task automatic wait_idle(input int bound, output bit expired);
        expired = 1'b1;
        for (int i = 0; i < bound; i++) begin
            if (!busy) begin
                expired = 1'b0;
                break;
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start: got %0h want 0", tx_start); end
        n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %0h want 00", tx_data); end
        n_cmp++; if (selection !== 4'hF) begin n_err++; $display("FAIL reset_selection: got %0h want F", selection); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0h want 0", busy); end
        n_cmp++; if (drop_cnt !== 8'h00) begin n_err++; $display("FAIL reset_drop_cnt: got %0h want 00", drop_cnt); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err: got %0h want 0", timeout_err); end
        n_cmp++; if (frame_cnt !== 16'h0000) begin n_err++; $display("FAIL reset_frame_cnt: got %0h want 0000", frame_cnt); end
        rst = 1'b0;
        tick();
        n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL idle_no_start: got %0h want 0", tx_start); end
    endtask

    task automatic test_single_frame();
        int  base;
        bit  to;
        logic [7:0] ed;
        logic [3:0] es;
        set_counts(8'h01);
        base = n_log;
        pulse_batch();
        n_cmp++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL single_start: got %0h want 1", tx_start); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %0h want 1", busy); end
        wait_idle(1000, to);
        n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL single_end_timeout: got %0h want 0", to); end
        n_cmp++; if (n_log - base != 11) begin n_err++; $display("FAIL single_len: got %0d want 11", n_log - base); end
        for (int i = 0; i < 11; i++) begin
            ed = (i == 0) ? 8'hA5 : (i == 10) ? 8'h01 : 8'(i);
            es = (i == 0 || i == 10) ? 4'hF : 4'(i - 1);
            n_cmp++; if (log_data[base+i] !== ed) begin n_err++; $display("FAIL single_byte%0d: got %0h want %0h", i, log_data[base+i], ed); end
            n_cmp++; if (log_sel[base+i] !== es) begin n_err++; $display("FAIL single_sel%0d: got %0h want %0h", i, log_sel[base+i], es); end
        end
        exp_frames++;
        n_cmp++; if (frame_cnt !== 16'(exp_frames)) begin n_err++; $display("FAIL single_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
        n_cmp++; if (viol != 0) begin n_err++; $display("FAIL single_handshake: got %0d violations want 0", viol); end
    endtask

    task automatic test_snapshot();
        int  base;
        bit  to;
        logic [7:0] ed;
        set_counts(8'h10);
        base = n_log;
        pulse_batch();
        counts_flat = '1;
        wait_idle(1000, to);
        n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL snap_end_timeout: got %0h want 0", to); end
        n_cmp++; if (n_log - base != 11) begin n_err++; $display("FAIL snap_len: got %0d want 11", n_log - base); end
        for (int i = 0; i < 11; i++) begin
            ed = (i == 0) ? 8'hA5 : (i == 10) ? 8'h18 : 8'h10 + 8'(i - 1);
            n_cmp++; if (log_data[base+i] !== ed) begin n_err++; $display("FAIL snap_byte%0d: got %0h want %0h", i, log_data[base+i], ed); end
        end
        exp_frames++;
        n_cmp++; if (frame_cnt !== 16'(exp_frames)) begin n_err++; $display("FAIL snap_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_back_to_back();
        int base;
        bit to;
        set_counts(8'h20);
        pulse_batch();
        wait_idle(1000, to);
        n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL b2b_first_timeout: got %0h want 0", to); end
        exp_frames++;
        n_cmp++; if (frame_cnt !== 16'(exp_frames)) begin n_err++; $display("FAIL b2b_frame_cnt1: got %0d want %0d", frame_cnt, exp_frames); end
        base = n_log;
        pulse_batch();
        n_cmp++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL b2b_start: got %0h want 1", tx_start); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %0h want 1", busy); end
        n_cmp++; if (drop_cnt !== 8'h00) begin n_err++; $display("FAIL b2b_drop_cnt: got %0d want 0", drop_cnt); end
        n_cmp++; if (log_data[base] !== 8'hA5) begin n_err++; $display("FAIL b2b_header: got %0h want a5", log_data[base]); end
        wait_idle(1000, to);
        exp_frames++;
        n_cmp++; if (log_data[base+10] !== 8'h28) begin n_err++; $display("FAIL b2b_csum: got %0h want 28", log_data[base+10]); end
        n_cmp++; if (frame_cnt !== 16'(exp_frames)) begin n_err++; $display("FAIL b2b_frame_cnt2: got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_timeout();
        int base;
        int cnt;
        bit to;
        set_counts(8'h01);
        base = n_log;
        mute_idx = base + 3;
        pulse_batch();
        cnt = 0;
        while (n_log < base + 3 && cnt < 500) begin tick(); cnt++; end
        n_cmp++; if (n_log != base + 3) begin n_err++; $display("FAIL tmo_third_byte: got %0d bytes want %0d", n_log - base, 3); end
        cnt = 0;
        while (timeout_err !== 1'b1 && cnt < 200) begin tick(); cnt++; end
        n_cmp++; if (cnt < 48 || cnt > 54) begin n_err++; $display("FAIL tmo_latency: got %0d cycles want 48..54", cnt); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL tmo_flag: got %0h want 1", timeout_err); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL tmo_busy: got %0h want 0", busy); end
        n_cmp++; if (frame_cnt !== 16'(exp_frames)) begin n_err++; $display("FAIL tmo_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
        mute_idx = -1;
        tick();
        base = n_log;
        pulse_batch();
        n_cmp++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL tmo_restart: got %0h want 1", tx_start); end
        n_cmp++; if (log_data[base] !== 8'hA5) begin n_err++; $display("FAIL tmo_restart_hdr: got %0h want a5", log_data[base]); end
        n_cmp++; if (log_sel[base] !== 4'hF) begin n_err++; $display("FAIL tmo_restart_sel: got %0h want f", log_sel[base]); end
        wait_idle(1000, to);
        exp_frames++;
        n_cmp++; if (frame_cnt !== 16'(exp_frames)) begin n_err++; $display("FAIL tmo_frame_cnt2: got %0d want %0d", frame_cnt, exp_frames); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: got %0h want 1", timeout_err); end
    endtask

    task automatic test_overrun();
        int base;
        int cnt;
        bit to;
        base = n_log;
        pulse_batch();
        repeat (10) tick();
        for (int i = 0; i < 3; i++) begin
            pulse_batch();
            tick();
        end
        n_cmp++; if (drop_cnt !== 8'd3) begin n_err++; $display("FAIL ovr_drop3: got %0d want 3", drop_cnt); end
        cnt = 0;
        while (!(tx_done === 1'b1 && n_log == base + 11) && cnt < 1000) begin tick(); cnt++; end
        n_cmp++; if (cnt >= 1000) begin n_err++; $display("FAIL ovr_final_done: got no final tx_done within %0d cycles", cnt); end
        pulse_batch();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovr_busy_fall: got %0h want 0", busy); end
        n_cmp++; if (drop_cnt !== 8'd4) begin n_err++; $display("FAIL ovr_drop4: got %0d want 4", drop_cnt); end
        repeat (5) tick();
        n_cmp++; if (n_log - base != 11) begin n_err++; $display("FAIL ovr_one_frame: got %0d bytes want 11", n_log - base); end
        exp_frames++;
        n_cmp++; if (frame_cnt !== 16'(exp_frames)) begin n_err++; $display("FAIL ovr_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
        for (int i = 0; i < 300; i++) begin
            pulse_batch();
            tick();
        end
        wait_idle(1000, to);
        n_cmp++; if (drop_cnt !== 8'd255) begin n_err++; $display("FAIL ovr_saturate: got %0d want 255", drop_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        int cnt;
        bit to;
        base = n_log;
        pulse_batch();
        cnt = 0;
        while (n_log < base + 6 && cnt < 500) begin tick(); cnt++; end
        repeat (5) tick();
        rst = 1'b1;
        #1;
        n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL rmid_tx_start: got %0h want 0", tx_start); end
        n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rmid_tx_data: got %0h want 00", tx_data); end
        n_cmp++; if (selection !== 4'hF) begin n_err++; $display("FAIL rmid_selection: got %0h want f", selection); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %0h want 0", busy); end
        n_cmp++; if (drop_cnt !== 8'h00) begin n_err++; $display("FAIL rmid_drop_cnt: got %0d want 0", drop_cnt); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rmid_timeout_err: got %0h want 0", timeout_err); end
        n_cmp++; if (frame_cnt !== 16'h0000) begin n_err++; $display("FAIL rmid_frame_cnt: got %0d want 0", frame_cnt); end
        repeat (3) tick();
        rst = 1'b0;
        base = n_log;
        repeat (100) tick();
        n_cmp++; if (n_log != base) begin n_err++; $display("FAIL rmid_quiet: got %0d tx_start want 0", n_log - base); end
        set_counts(8'h01);
        pulse_batch();
        n_cmp++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL rmid_restart: got %0h want 1", tx_start); end
        wait_idle(1000, to);
        n_cmp++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL rmid_frame_cnt2: got %0d want 1", frame_cnt); end
        n_cmp++; if (log_data[n_log-1] !== 8'h01) begin n_err++; $display("FAIL rmid_csum: got %0h want 01", log_data[n_log-1]); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_snapshot();
        test_back_to_back();
        test_timeout();
        test_overrun();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_bound: simulation exceeded time limit, compared %0d", n_cmp);
        $fatal(1, "bench time limit");
    end

endmodule
`default_nettype wire

// File: doc/readout_sequencer.md
# readout_sequencer

Frame scheduler between the nine per-batch count registers and the UART byte transmitter. On each `batch_done` it snapshots all channel counts, then drives the transmitter one byte at a time: a sync header, the nine counts in fixed order, then an XOR checksum. It owns the transmitter handshake, reports the active channel on `selection`, and detects dropped batches and a stalled transmitter.

## Interface
- `N_CH`, 9: number of count channels. Order is A, B, BP, AP, AB, ABP, APB, APBP, ABBP.
- `SYNC_BYTE`, 8'hA5: frame header byte.
- `TIMEOUT_CYC`, 65535: maximum `clk` cycles to wait for `tx_done` per byte.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `batch_done`  in  1  one-cycle pulse marking the end of a counting batch.
- `counts_flat`  in  8*N_CH  channel counts; channel k is at bits [8k+7:8k], k=0 is A.
- `tx_done`  in  1  one-cycle pulse from the transmitter when the current byte has finished.
- `tx_start`  out  1  one-cycle request to send `tx_data`.
- `tx_data`  out  8  byte to send; held stable from `tx_start` until `tx_done`.
- `selection`  out  4  channel index being sent (0..N_CH-1); 4'hF during header or checksum.
- `busy`  out  1  high from frame acceptance until the frame ends.
- `drop_cnt`  out  8  number of batches ignored while busy; saturates at 255.
- `timeout_err`  out  1  sticky; set when a byte times out.
- `frame_cnt`  out  16  number of completed frames; wraps at 2^16.

## Operation
- States: IDLE, HDR, HDR_W, DAT, DAT_W, CSUM, CSUM_W.
- IDLE:
  - On `batch_done`, latch `counts_flat` into the snapshot, clear the checksum accumulator, set `busy`, and go to HDR.
  - Otherwise stay in IDLE.
- HDR: pulse `tx_start` with `tx_data`=`SYNC_BYTE` and `selection`=4'hF. Go to HDR_W.
- HDR_W: on `tx_done`, set `ch_idx`=0 and go to DAT.
- DAT:
  - Pulse `tx_start` with `tx_data`=snapshot[`ch_idx`] and `selection`=`ch_idx`.
  - Update the accumulator: acc ^= that byte.
  - Go to DAT_W.
- DAT_W, on `tx_done`:
  - If `ch_idx`==N_CH-1, go to CSUM.
  - Otherwise increment `ch_idx` and go to DAT.
- CSUM: pulse `tx_start` with `tx_data`=acc and `selection`=4'hF. Go to CSUM_W.
- CSUM_W: on `tx_done`, increment `frame_cnt`, clear `busy`, and go to IDLE.
- Snapshot isolation: the snapshot is taken only in IDLE. Changes to `counts_flat` during a frame do not affect it.
- Dropped batches: `batch_done` in any state other than IDLE increments `drop_cnt` (saturating) and otherwise has no effect.
- Watchdog:
  - A counter clears on every `tx_start` and increments in each *_W state.
  - If it reaches `TIMEOUT_CYC` before `tx_done`, set `timeout_err`, clear `busy`, and go to IDLE. `frame_cnt` is not incremented.
  - `timeout_err` clears only on `rst`.
- Stray `tx_done`: ignored when it arrives in IDLE, HDR, DAT or CSUM.
- Frame length: N_CH+2 bytes, 11 at the defaults.

## Timing
- Reset values: state IDLE; `tx_start`=0, `tx_data`=0, `selection`=4'hF, `busy`=0, `drop_cnt`=0, `timeout_err`=0, `frame_cnt`=0. Snapshot, accumulator and watchdog all 0.
- Reset mid-frame aborts immediately. No further `tx_start` is issued until a new `batch_done` is accepted.
- Frame start: `batch_done` high in cycle t (IDLE) puts `busy` high from t+1 and `tx_start` high for exactly cycle t+1.
- Byte-to-byte: `tx_done` in cycle u puts the next `tx_start` in cycle u+1. The output sequence is a single `tx_start` cycle followed by wait cycles.
- `tx_data` and `selection` are registered. They change only in the cycle `tx_start` rises.
- `busy` falls in the cycle after the final `tx_done`. A `batch_done` coincident with that final `tx_done` counts as dropped.
- A `batch_done` in the first IDLE cycle after a frame is accepted.

## Test plan
- Single frame: counts 1..9 (A=1 … ABBP=9), `batch_done`, transmitter model returns `tx_done` 20 cycles after each `tx_start` -> bytes A5,01,02,…,09,01 (XOR of 1..9), with `selection` F,0..8,F. Then `frame_cnt`=1, `busy`=0.
- Snapshot isolation: change `counts_flat` to all 8'hFF right after acceptance -> transmitted bytes are still the originally latched values.
- Overrun: three `batch_done` pulses during one frame, plus one coincident with the final `tx_done` -> `drop_cnt`=4 and exactly one frame sent. Then 300 pulses across frames -> `drop_cnt` saturates at 255.
- Timeout: `TIMEOUT_CYC`=50, transmitter never answers the 3rd byte -> `timeout_err`=1 about 50 cycles after that `tx_start`, `busy`=0, `frame_cnt` unchanged. The next `batch_done` starts a fresh frame with header A5.
- Reset mid-frame: assert `rst` during DAT_W of channel 4 -> all outputs return to reset values asynchronously, and there is no `tx_start` after release until `batch_done`.
- Back-to-back: `batch_done` in the first IDLE cycle after a frame -> accepted, `tx_start` the next cycle, `drop_cnt` unchanged.
